// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Holds the exception field widths and the per-entry exception record used
// by the instruction response queue. No ports; import with cpu_pkg::*.
package cpu_pkg;

    localparam int ECODE_W    = 6;
    localparam int ESUBCODE_W = 9;

    // Exception record stored with every queue entry. Width-parameterised
    // payload (pc, inst) is kept beside it in the queue itself.
    typedef struct packed {
        logic                  has_exc;
        logic [ECODE_W-1:0]    ecode;
        logic [ESUBCODE_W-1:0] esubcode;
    } iq_entry_exc_t;

endpackage

// File: rtl/discard_counter.sv
// Counts memory responses that still have to be thrown away after a flush.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   add           responses newly orphaned this cycle (non-zero only on flush)
//   dec           one orphaned response arrived and was dropped this cycle
//   count         responses still to be dropped
module discard_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [CW-1:0] add,
    input  logic          dec,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q + add - CW'(dec);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/inst_resp_queue.sv
// In-order instruction fetch response queue.
// Tracks up to DEPTH fetches from issue to decode. Each entry carries the PC,
// the returned instruction, any fetch-time exception and pending/done flags.
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   req_valid/req_pc/req_exc/...        new fetch slot (memory issued or exception)
//   req_ready                           a new slot may be pushed this cycle
//   data_ok/rdata                       in-order memory response
//   flush                               redirect: drop everything in flight
//   out_valid/out_ready/out_*           head entry towards decode
//   count/discard_cnt                   occupancy / responses still to drop
//   resp_err                            sticky: response arrived with nothing waiting
module inst_resp_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  logic [DATA_W-1:0]     req_pc,
    input  logic                  req_exc,
    input  logic [ECODE_W-1:0]    req_ecode,
    input  logic [ESUBCODE_W-1:0] req_esubcode,
    output logic                  req_ready,
    input  logic                  data_ok,
    input  logic [DATA_W-1:0]     rdata,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_pc,
    output logic [DATA_W-1:0]     out_inst,
    output logic                  out_has_exception,
    output logic [ECODE_W-1:0]    out_ecode,
    output logic [ESUBCODE_W-1:0] out_esubcode,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         discard_cnt,
    output logic                  resp_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] pending_q, pending_d, done_q, done_d;
    logic             resp_err_q, resp_err_d;

    // Payload storage; only the flags above need a reset value.
    logic [DATA_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    iq_entry_exc_t     exc_mem  [DEPTH];

    logic          push, pop, fill, drop_dec, discard_zero, head_ok;
    logic          fill_found;
    logic [PW-1:0] fill_idx, scan_idx;
    logic [CW-1:0] pend_cnt, discard_add;

    assign discard_zero = (discard_cnt == '0);
    assign req_ready    = ({1'b0, count_q} + {1'b0, discard_cnt}) < DEPTH_LIM;
    assign push         = req_valid && req_ready;
    assign head_ok      = (count_q != '0);
    assign out_valid    = head_ok && done_q[head_q] && !flush;
    assign pop          = out_valid && out_ready;
    assign fill         = data_ok && discard_zero && fill_found;
    assign drop_dec     = data_ok && !discard_zero;

    // Oldest pending entry: scan from the head, walking backwards so the
    // entry closest to the head is the last one to win.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = head_q;
        scan_idx   = head_q;
        pend_cnt   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            scan_idx = head_q + PW'(i);
            if (pending_q[scan_idx]) begin
                fill_found = 1'b1;
                fill_idx   = scan_idx;
            end
            pend_cnt = pend_cnt + CW'(pending_q[i]);
        end
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pending_d  = pending_q;
        done_d     = done_q;
        resp_err_d = resp_err_q | (data_ok && discard_zero && !fill_found);
        discard_add = '0;
        if (flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            pending_d = '0;
            done_d    = '0;
            // Every fetch still out in memory becomes an orphan, including a
            // fetch issued this very cycle; a response filling this cycle
            // has already returned and is not counted.
            discard_add = pend_cnt - CW'(fill) + CW'(push && !req_exc);
        end else begin
            if (fill) begin
                pending_d[fill_idx] = 1'b0;
                done_d[fill_idx]    = 1'b1;
            end
            if (pop) begin
                done_d[head_q] = 1'b0;
                head_d         = head_q + PW'(1);
            end
            if (push) begin
                pending_d[tail_q] = !req_exc;
                done_d[tail_q]    = req_exc;
                tail_d            = tail_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            done_q     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Exception slots store inst=0 at push so the head reads 0 for them.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[tail_q]   <= req_pc;
            inst_mem[tail_q] <= '0;
            exc_mem[tail_q]  <= '{has_exc:  req_exc,
                                  ecode:    req_exc ? req_ecode : '0,
                                  esubcode: req_exc ? req_esubcode : '0};
        end
        if (fill && !flush) begin
            inst_mem[fill_idx] <= rdata;
        end
    end

    discard_counter #(.CW(CW)) u_discard (
        .clk    (clk),
        .resetn (resetn),
        .add    (discard_add),
        .dec    (drop_dec),
        .count  (discard_cnt)
    );

    assign out_pc            = head_ok ? pc_mem[head_q]            : '0;
    assign out_inst          = head_ok ? inst_mem[head_q]          : '0;
    assign out_has_exception = head_ok ? exc_mem[head_q].has_exc   : 1'b0;
    assign out_ecode         = head_ok ? exc_mem[head_q].ecode     : '0;
    assign out_esubcode      = head_ok ? exc_mem[head_q].esubcode  : '0;
    assign count             = count_q;
    assign resp_err          = resp_err_q;

endmodule
